cpu_fw_scoreboard: RTL
======================

Name: cpu_fw_scoreboard

Overview:
- Producer-side tracker for the forwarding path.
- Shadows destination register, write-enable and load flag of every in-flight instruction through EX, COMMIT and WB.
- Generates registered ra/rb bypass selects for the instruction entering EX, and the 1-cycle load-use stall back to ID.
- Sits between decode and the execute stage. It drives the bypass selects that execute consumes alongside commit_value/wb_value.

Parameters:
- NUM_REGS, 16, architectural register count; register index width is $clog2(NUM_REGS).

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous reset, active-low
- id_valid  in  1  valid instruction in ID
- id_ra  in  $clog2(NUM_REGS)  source A index
- id_rb  in  $clog2(NUM_REGS)  source B index
- id_uses_ra  in  1  instruction reads ra
- id_uses_rb  in  1  instruction reads rb
- id_rd  in  $clog2(NUM_REGS)  destination index
- id_writeback  in  1  instruction writes rd
- id_is_load  in  1  result only available at WB
- freeze  in  1  global pipeline hold
- flush  in  1  kill the ID instruction (branch resolved in EX)
- id_stall  out  1  combinational; ID must hold its instruction
- ra_bypass  out  2  registered select for EX operand A
- rb_bypass  out  2  registered select for EX operand B
- ex_valid  out  1  EX shadow entry valid (debug/observability)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n).
- Shadow stages: three entries, EX, CM (commit) and WB. Each entry holds {valid, rd, wb, load}.
- Reset: all entries invalid; ra_bypass = rb_bypass = BYP_RF; ex_valid = 0.
  - id_stall is 0 during reset because all entries are invalid.
  - Reset applied mid-sequence discards all in-flight state in the same edge.
- hazard (combinational) = id_valid & EX.valid & EX.wb & EX.load & ((id_uses_ra & id_ra == EX.rd) | (id_uses_rb & id_rb == EX.rd)).
- id_stall = hazard | freeze.
- Each edge with freeze = 0:
  - WB <= CM.
  - CM <= EX.
  - EX <= ID entry if id_valid & !hazard & !flush; otherwise EX <= bubble (valid = 0, bypass = BYP_RF).
- Each edge with freeze = 1: all state and outputs hold. A flush asserted during freeze is ignored; its source must hold it until freeze drops.
- Bypass select, computed at ID time and registered into EX with the instruction, per operand:
  - If the operand is used and EX.valid & EX.wb & EX.rd == src, then BYP_COMMIT. This is the producer one ahead; its value is on commit_value next cycle.
  - Else if CM.valid & CM.wb & CM.rd == src, then BYP_WB.
  - Else BYP_RF. The register file is write-through, so the current WB producer needs no bypass.
- Priority: the youngest match wins (EX over CM).
- Operand not used gives BYP_RF.
- Load in EX with a matching consumer causes a stall for exactly one cycle. Next cycle the load is in CM, so the select becomes BYP_WB.
- Load in CM (not EX) with a match gives BYP_WB, with no stall.
- Code 2'b11 is never generated.
- Latency: ra_bypass/rb_bypass are valid in the same cycle the instruction occupies EX, one edge after the ID-side compare.

Optional Feature:
- CPU_FW_R0_ZERO_EN defined: register 0 is hardwired zero.
  - Any src == 0 yields BYP_RF.
  - A load targeting r0 never raises hazard.
  - Entries with rd == 0 are stored with wb = 0.
- Undefined: r0 is an ordinary register, handled like every other index.

Decomposition:
- Package cpu_fw_pkg:
  - Localparams BYP_RF = 2'b00, BYP_COMMIT = 2'b01, BYP_WB = 2'b10.
  - Typedef fw_entry_t {valid, rd, wb, load}.
- Sub-module cpu_fw_match: combinational single-operand comparator (src, uses, EX entry, CM entry → 2-bit select, load-hit flag). Instantiated twice, for ra and rb.

Test Plan:
- ALU write r3, next instruction reads ra = r3 → consumer in EX shows ra_bypass = 01, rb_bypass = 00, id_stall never asserted.
- ALU write r3, unrelated instruction, then read rb = r3 → rb_bypass = 10 when the consumer is in EX.
- Load r5, next instruction reads ra = r5 → id_stall = 1 for exactly 1 cycle, one bubble in EX (ex_valid = 0), then ra_bypass = 10.
- Two consecutive writes to r4, then read of r4 on both operands → ra_bypass = rb_bypass = 01 (youngest wins).
- Write r0, then read ra = r0 → 00 with CPU_FW_R0_ZERO_EN defined, 01 without it.
- freeze held 3 cycles mid-sequence → all outputs unchanged, and the sequence resumes identically. reset_n = 0 for 1 cycle mid-sequence → next cycle outputs are 00/00, ex_valid = 0, id_stall = 0.

Source files
------------

// File: rtl/cpu_fw_pkg.sv
// Shared types and bypass-select encodings for the forwarding scoreboard.
// Optional feature macro: CPU_FW_R0_ZERO_EN (register 0 hardwired to zero).
package cpu_fw_pkg;

   localparam logic [1:0] BYP_RF     = 2'b00;
   localparam logic [1:0] BYP_COMMIT = 2'b01;
   localparam logic [1:0] BYP_WB     = 2'b10;

   // rd is stored at a fixed maximum width so the entry type is independent of NUM_REGS
   localparam int IDX_W = 8;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] rd;
      logic             wb;
      logic             load;
   } fw_entry_t;

   localparam fw_entry_t FW_BUBBLE = '{default: '0};

endpackage

// File: rtl/cpu_fw_match.sv
// Single-operand producer comparator: picks the bypass select and flags a load-use hit.
// Optional feature macro: CPU_FW_R0_ZERO_EN.
module cpu_fw_match
   import cpu_fw_pkg::*;
(
   input  logic [IDX_W-1:0] src,
   input  logic             uses,
   input  fw_entry_t        ex_entry,
   input  fw_entry_t        cm_entry,
   output logic [1:0]       sel,
   output logic             load_hit
);

   logic src_live;
   logic ex_hit;
   logic cm_hit;
   logic unused_cm_load;

`ifdef CPU_FW_R0_ZERO_EN
   assign src_live = uses && (src != '0);
`else
   assign src_live = uses;
`endif

   assign ex_hit   = src_live && ex_entry.valid && ex_entry.wb && (ex_entry.rd == src);
   assign cm_hit   = src_live && cm_entry.valid && cm_entry.wb && (cm_entry.rd == src);
   assign load_hit = ex_hit && ex_entry.load;

   // A load in CM is already forwardable from WB next cycle, so its load bit is irrelevant here
   assign unused_cm_load = cm_entry.load;

   // Youngest producer wins
   always_comb begin
      sel = BYP_RF;
      if (ex_hit)
         sel = BYP_COMMIT;
      else if (cm_hit)
         sel = BYP_WB;
   end

endmodule

// File: rtl/cpu_fw_scoreboard.sv
// Forwarding scoreboard: shadows EX/CM/WB producers, registers bypass selects, raises load-use stall.
// Optional feature macro: CPU_FW_R0_ZERO_EN.
module cpu_fw_scoreboard
   import cpu_fw_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        id_valid,
   input  logic [$clog2(NUM_REGS)-1:0] id_ra,
   input  logic [$clog2(NUM_REGS)-1:0] id_rb,
   input  logic                        id_uses_ra,
   input  logic                        id_uses_rb,
   input  logic [$clog2(NUM_REGS)-1:0] id_rd,
   input  logic                        id_writeback,
   input  logic                        id_is_load,
   input  logic                        freeze,
   input  logic                        flush,
   output logic                        id_stall,
   output logic [1:0]                  ra_bypass,
   output logic [1:0]                  rb_bypass,
   output logic                        ex_valid
);

   fw_entry_t  ex_q;
   fw_entry_t  cm_q;
   fw_entry_t  wb_q;
   fw_entry_t  id_entry;
   logic [1:0] ra_sel;
   logic [1:0] rb_sel;
   logic       ra_load_hit;
   logic       rb_load_hit;
   logic       hazard;
   logic       accept;
   logic       unused_wb;

   cpu_fw_match u_match_ra (
      .src      (IDX_W'(id_ra)),
      .uses     (id_uses_ra),
      .ex_entry (ex_q),
      .cm_entry (cm_q),
      .sel      (ra_sel),
      .load_hit (ra_load_hit)
   );

   cpu_fw_match u_match_rb (
      .src      (IDX_W'(id_rb)),
      .uses     (id_uses_rb),
      .ex_entry (ex_q),
      .cm_entry (cm_q),
      .sel      (rb_sel),
      .load_hit (rb_load_hit)
   );

   assign hazard   = id_valid && (ra_load_hit || rb_load_hit);
   assign id_stall = hazard || freeze;
   assign accept   = id_valid && !hazard && !flush;
   assign ex_valid = ex_q.valid;

   // WB is tracked for completeness; the write-through register file makes it bypass-free
   assign unused_wb = ^wb_q;

   always_comb begin
      id_entry       = FW_BUBBLE;
      id_entry.valid = 1'b1;
      id_entry.rd    = IDX_W'(id_rd);
      id_entry.load  = id_is_load;
`ifdef CPU_FW_R0_ZERO_EN
      id_entry.wb    = id_writeback && (id_rd != '0);
`else
      id_entry.wb    = id_writeback;
`endif
   end

   // Pipeline advance; freeze holds every stage and the registered selects
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_q      <= FW_BUBBLE;
         cm_q      <= FW_BUBBLE;
         wb_q      <= FW_BUBBLE;
         ra_bypass <= BYP_RF;
         rb_bypass <= BYP_RF;
      end else if (!freeze) begin
         wb_q <= cm_q;
         cm_q <= ex_q;
         if (accept) begin
            ex_q      <= id_entry;
            ra_bypass <= ra_sel;
            rb_bypass <= rb_sel;
         end else begin
            ex_q      <= FW_BUBBLE;
            ra_bypass <= BYP_RF;
            rb_bypass <= BYP_RF;
         end
      end
   end

endmodule
